// File: rtl/missile_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module   : missile_pkg
// Brief    : Shared types, screen constants and span helpers for missile_engine.
// Revision : 1.0 - initial release
// ============================================================================
package missile_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef struct packed {
        logic       valid;
        logic [9:0] x;
        logic [9:0] y;
    } missile_slot_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        SPAWN  = 2'd2
    } missile_state_e;

    // 11-bit compares so lo+len never wraps past 1023
    function automatic logic in_span(input logic [9:0] lo, input logic [9:0] pos,
                                     input logic [10:0] len);
        return ({1'b0, lo} <= {1'b0, pos}) && ({1'b0, pos} < ({1'b0, lo} + len));
    endfunction

    function automatic logic spans_overlap(input logic [9:0] a_lo, input logic [10:0] a_len,
                                           input logic [9:0] b_lo, input logic [10:0] b_len);
        return ({1'b0, a_lo} < ({1'b0, b_lo} + b_len)) && ({1'b0, b_lo} < ({1'b0, a_lo} + a_len));
    endfunction

endpackage
`default_nettype wire

// File: rtl/missile_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : missile_engine_if
// Brief    : Fire handshake, plane/enemy positions, pixel query and status.
// Revision : 1.0 - initial release
// ============================================================================
interface missile_engine_if;

    logic       fire_req;
    logic       fire_ack;
    logic [9:0] plane_x;
    logic [9:0] plane_y;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       is_missle;
    logic [3:0] missile_count;
    logic [9:0] enemy_x;
    logic [9:0] enemy_y;
    logic       hit;

    modport master (
        output fire_req, plane_x, plane_y, DrawX, DrawY, enemy_x, enemy_y,
        input  fire_ack, is_missle, missile_count, hit
    );

    modport slave (
        input  fire_req, plane_x, plane_y, DrawX, DrawY, enemy_x, enemy_y,
        output fire_ack, is_missle, missile_count, hit
    );

endinterface
`default_nettype wire

// File: rtl/missile_engine_frame_tick_sync.sv
`default_nettype none
// ============================================================================
// Module   : frame_tick_sync
// Brief    : Two-flop synchroniser for raw vsync plus rising-edge detector.
// Revision : 1.0 - initial release
// ============================================================================
module frame_tick_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_frame_clk,
    output logic o_tick
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_frame_clk;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_tick = r_sync & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/missile_engine.sv
`default_nettype none
// ============================================================================
// Module   : missile_engine
// Brief    : Player missile pool: spawn on fire, per-frame move/retire, pixel
//            hit flag. Optional enemy collision when MISSILE_HIT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module missile_engine
    import missile_pkg::*;
#(
    parameter int N_MISSILES      = 4,
    parameter int MISSILE_W       = 4,
    parameter int MISSILE_H       = 8,
    parameter int PLANE_W         = 32,
    parameter int SPEED           = 4,
    parameter int COOLDOWN_FRAMES = 8,
    parameter int ENEMY_W         = 32,
    parameter int ENEMY_H         = 32
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic frame_clk,
    missile_engine_if.slave bus
);

    localparam int c_IDX_W = (N_MISSILES > 1) ? $clog2(N_MISSILES) : 1;
    localparam int c_CD_W  = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

    localparam logic [c_IDX_W-1:0] c_LAST_IDX  = c_IDX_W'(N_MISSILES - 1);
    localparam logic [c_CD_W-1:0]  c_CD_RELOAD = c_CD_W'(COOLDOWN_FRAMES);
    localparam logic [9:0]         c_SPEED     = 10'(SPEED);
    localparam logic [9:0]         c_MH        = 10'(MISSILE_H);
    localparam logic [9:0]         c_X_OFS     = 10'(PLANE_W / 2 - MISSILE_W / 2);
    localparam logic [10:0]        c_MW11      = 11'(MISSILE_W);
    localparam logic [10:0]        c_MH11      = 11'(MISSILE_H);

    missile_slot_t        r_slots [N_MISSILES];
    missile_state_e       r_state;
    logic [c_IDX_W-1:0]   r_idx;
    logic [c_CD_W-1:0]    r_cooldown;
    logic                 r_fire_ack;
    logic                 r_hit;
    logic [3:0]           r_count;

    logic                 w_tick;
    logic                 w_free_found;
    logic [c_IDX_W-1:0]   w_free_idx;
    logic [3:0]           w_live;
    logic                 w_spawn_ok;
    logic                 w_retire_top;
    logic [9:0]           w_next_y;
    logic                 w_hit_now;
    logic                 w_is_missle;

    frame_tick_sync u_tick_sync (
        .clk         (Clk),
        .rst_n       (Reset_n),
        .i_frame_clk (frame_clk),
        .o_tick      (w_tick)
    );

    // Descending scan so the lowest free index wins
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        w_live       = '0;
        for (int i = N_MISSILES - 1; i >= 0; i--) begin
            if (!r_slots[i].valid) begin
                w_free_found = 1'b1;
                w_free_idx   = c_IDX_W'(i);
            end
            w_live = w_live + {3'b000, r_slots[i].valid};
        end
    end

    assign w_spawn_ok   = bus.fire_req && (r_cooldown == '0) && w_free_found && (bus.plane_y >= c_MH);
    assign w_retire_top = r_slots[r_idx].y < c_SPEED;
    assign w_next_y     = r_slots[r_idx].y - c_SPEED;

`ifdef MISSILE_HIT_EN
    assign w_hit_now = r_slots[r_idx].valid && !w_retire_top
                       && spans_overlap(r_slots[r_idx].x, c_MW11, bus.enemy_x, 11'(ENEMY_W))
                       && spans_overlap(w_next_y, c_MH11, bus.enemy_y, 11'(ENEMY_H));
`else
    logic w_unused_enemy;
    assign w_unused_enemy = ^{bus.enemy_x, bus.enemy_y, 32'(ENEMY_W), 32'(ENEMY_H)};
    assign w_hit_now      = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_cooldown <= '0;
            r_fire_ack <= 1'b0;
            r_hit      <= 1'b0;
            r_count    <= '0;
            for (int i = 0; i < N_MISSILES; i++) begin
                r_slots[i] <= '0;
            end
        end else begin
            r_fire_ack <= 1'b0;
            r_hit      <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_tick) begin
                        r_state <= UPDATE;
                        r_idx   <= '0;
                        if (r_cooldown != '0) begin
                            r_cooldown <= r_cooldown - 1'b1;
                        end
                    end
                end
                UPDATE: begin
                    if (r_slots[r_idx].valid) begin
                        if (w_retire_top || w_hit_now) begin
                            r_slots[r_idx].valid <= 1'b0;
                        end else begin
                            r_slots[r_idx].y <= w_next_y;
                        end
                        r_hit <= w_hit_now;
                    end
                    if (r_idx == c_LAST_IDX) begin
                        r_state <= SPAWN;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                SPAWN: begin
                    if (w_spawn_ok) begin
                        r_slots[w_free_idx] <= '{valid: 1'b1,
                                                 x:     bus.plane_x + c_X_OFS,
                                                 y:     bus.plane_y - c_MH};
                        r_cooldown <= c_CD_RELOAD;
                        r_fire_ack <= 1'b1;
                        r_count    <= w_live + 4'd1;
                    end else begin
                        r_count    <= w_live;
                    end
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        w_is_missle = 1'b0;
        for (int i = 0; i < N_MISSILES; i++) begin
            if (r_slots[i].valid
                && in_span(r_slots[i].x, bus.DrawX, c_MW11)
                && in_span(r_slots[i].y, bus.DrawY, c_MH11)) begin
                w_is_missle = 1'b1;
            end
        end
    end

    assign bus.fire_ack      = r_fire_ack;
    assign bus.hit           = r_hit;
    assign bus.missile_count = r_count;
    assign bus.is_missle     = w_is_missle;

endmodule
`default_nettype wire
